// File: rtl/psum_mem_arbiter.sv
// Arbitrates the single-port partial-sum SRAM between the convolution controller and the
// host readback port, using an in-order write buffer with youngest-match read forwarding.
module psum_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 20,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WB_DEPTH     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  arst_n_in,
    input  logic                  ctrl_we,
    input  logic [ADDR_WIDTH-1:0] ctrl_waddr,
    input  logic [DATA_WIDTH-1:0] ctrl_wdata,
    input  logic                  ctrl_re,
    input  logic [ADDR_WIDTH-1:0] ctrl_raddr,
    output logic                  ctrl_stall,
    output logic                  ctrl_rvalid,
    output logic [DATA_WIDTH-1:0] ctrl_rdata,
    input  logic                  host_req,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  wb_busy,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int unsigned CNT_W  = $clog2(WB_DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        SlotNone, SlotHostStarve, SlotDrainFull, SlotCtrlRead, SlotHostRead, SlotDrain
    } slot_e;

    typedef enum logic [1:0] {OwnNone, OwnCtrl, OwnHost} owner_e;

    // Entry 0 is the oldest; valid entries occupy [0, wb_cnt_q).
    logic [ADDR_WIDTH-1:0] wb_addr_q [WB_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data_q [WB_DEPTH];
    logic [ADDR_WIDTH-1:0] wb_addr_d [WB_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data_d [WB_DEPTH];
    logic [CNT_W-1:0]      wb_cnt_q, wb_cnt_d;
    logic [WAIT_W-1:0]     host_wait_q, host_wait_d;
    owner_e                owner_q, owner_d;
    logic                  ctrl_rvalid_q, host_rvalid_q, wb_busy_q;
    logic [DATA_WIDTH-1:0] ctrl_fwd_data_q, host_fwd_data_q;
    logic [DATA_WIDTH-1:0] ctrl_rdata_q, host_rdata_q;

    logic                  ctrl_hit, host_hit;
    logic [DATA_WIDTH-1:0] ctrl_hit_data, host_hit_data;
    logic                  full, empty, drain, ctrl_enq, ctrl_acc;
    slot_e                 slot;

    // Later (younger) matches overwrite earlier ones.
    always_comb begin
        ctrl_hit      = 1'b0;
        host_hit      = 1'b0;
        ctrl_hit_data = '0;
        host_hit_data = '0;
        for (int i = 0; i < int'(WB_DEPTH); i++) begin
            if (CNT_W'(i) < wb_cnt_q) begin
                if (wb_addr_q[i] == ctrl_raddr) begin
                    ctrl_hit      = 1'b1;
                    ctrl_hit_data = wb_data_q[i];
                end
                if (wb_addr_q[i] == host_addr) begin
                    host_hit      = 1'b1;
                    host_hit_data = wb_data_q[i];
                end
            end
        end
    end

    assign full  = (wb_cnt_q == CNT_W'(WB_DEPTH));
    assign empty = (wb_cnt_q == '0);

    always_comb begin
        slot = SlotNone;
        if (!arst_n_in) begin
            slot = SlotNone;
        end else if (host_req && !host_hit && host_wait_q == WAIT_W'(STARVE_LIMIT)) begin
            slot = SlotHostStarve;
        end else if (full) begin
            slot = SlotDrainFull;
        end else if (ctrl_re && !ctrl_hit) begin
            slot = SlotCtrlRead;
        end else if (host_req && !host_hit) begin
            slot = SlotHostRead;
        end else if (!empty) begin
            slot = SlotDrain;
        end
    end

    assign drain      = (slot == SlotDrainFull) || (slot == SlotDrain);
    assign ctrl_stall = (ctrl_re && !ctrl_hit && slot != SlotCtrlRead) ||
                        (ctrl_we && full && !drain);
    assign host_gnt   = host_req && (host_hit || slot == SlotHostStarve || slot == SlotHostRead);
    assign ctrl_enq   = ctrl_we && !ctrl_stall;
    assign ctrl_acc   = ctrl_re && !ctrl_stall;

    assign sram_en    = (slot != SlotNone);
    assign sram_we    = drain;
    assign sram_wdata = wb_data_q[0];

    always_comb begin
        sram_addr = '0;
        unique case (slot)
            SlotDrainFull, SlotDrain:     sram_addr = wb_addr_q[0];
            SlotCtrlRead:                 sram_addr = ctrl_raddr;
            SlotHostStarve, SlotHostRead: sram_addr = host_addr;
            default:                      sram_addr = '0;
        endcase
    end

    always_comb begin
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_cnt_d  = wb_cnt_q;
        if (drain) begin
            for (int i = 0; i < int'(WB_DEPTH) - 1; i++) begin
                wb_addr_d[i] = wb_addr_q[i+1];
                wb_data_d[i] = wb_data_q[i+1];
            end
            wb_cnt_d = wb_cnt_q - CNT_W'(1);
        end
        if (ctrl_enq) begin
            for (int i = 0; i < int'(WB_DEPTH); i++) begin
                if (CNT_W'(i) == wb_cnt_d) begin
                    wb_addr_d[i] = ctrl_waddr;
                    wb_data_d[i] = ctrl_wdata;
                end
            end
            wb_cnt_d = wb_cnt_d + CNT_W'(1);
        end
    end

    always_comb begin
        host_wait_d = host_wait_q;
        if (host_gnt) begin
            host_wait_d = '0;
        end else if (host_req && host_wait_q < WAIT_W'(STARVE_LIMIT)) begin
            host_wait_d = host_wait_q + WAIT_W'(1);
        end
        owner_d = OwnNone;
        if (slot == SlotCtrlRead) begin
            owner_d = OwnCtrl;
        end else if (slot == SlotHostStarve || slot == SlotHostRead) begin
            owner_d = OwnHost;
        end
    end

    // SRAM data only belongs to a port when that port owned last cycle's read slot.
    always_comb begin
        ctrl_rdata = ctrl_rdata_q;
        host_rdata = host_rdata_q;
        if (owner_q == OwnCtrl) begin
            ctrl_rdata = sram_rdata;
        end else if (ctrl_rvalid_q) begin
            ctrl_rdata = ctrl_fwd_data_q;
        end
        if (owner_q == OwnHost) begin
            host_rdata = sram_rdata;
        end else if (host_rvalid_q) begin
            host_rdata = host_fwd_data_q;
        end
    end

    assign ctrl_rvalid = ctrl_rvalid_q;
    assign host_rvalid = host_rvalid_q;
    assign wb_busy     = wb_busy_q;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wb_addr_q       <= '{default: '0};
            wb_data_q       <= '{default: '0};
            wb_cnt_q        <= '0;
            host_wait_q     <= '0;
            owner_q         <= OwnNone;
            ctrl_rvalid_q   <= 1'b0;
            host_rvalid_q   <= 1'b0;
            wb_busy_q       <= 1'b0;
            ctrl_fwd_data_q <= '0;
            host_fwd_data_q <= '0;
            ctrl_rdata_q    <= '0;
            host_rdata_q    <= '0;
        end else begin
            wb_addr_q       <= wb_addr_d;
            wb_data_q       <= wb_data_d;
            wb_cnt_q        <= wb_cnt_d;
            host_wait_q     <= host_wait_d;
            owner_q         <= owner_d;
            ctrl_rvalid_q   <= ctrl_acc;
            host_rvalid_q   <= host_gnt;
            wb_busy_q       <= (wb_cnt_d != '0);
            ctrl_fwd_data_q <= ctrl_hit_data;
            host_fwd_data_q <= host_hit_data;
            ctrl_rdata_q    <= ctrl_rdata;
            host_rdata_q    <= host_rdata;
        end
    end

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Bench for psum_mem_arbiter: directed vector table, hand-built starvation and reset
// sequences, then random traffic checked against a queue-based memory model.
module tb_psum_mem_arbiter;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        ctrl_we, ctrl_re, host_req;
    logic [19:0] ctrl_waddr, ctrl_raddr, host_addr;
    logic [31:0] ctrl_wdata;
    logic        ctrl_stall, ctrl_rvalid, host_gnt, host_rvalid, wb_busy;
    logic [31:0] ctrl_rdata, host_rdata;
    logic        sram_en, sram_we;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    always #5 clk = ~clk;

    psum_mem_arbiter dut (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .ctrl_we    (ctrl_we),
        .ctrl_waddr (ctrl_waddr),
        .ctrl_wdata (ctrl_wdata),
        .ctrl_re    (ctrl_re),
        .ctrl_raddr (ctrl_raddr),
        .ctrl_stall (ctrl_stall),
        .ctrl_rvalid(ctrl_rvalid),
        .ctrl_rdata (ctrl_rdata),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .wb_busy    (wb_busy),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // SRAM macro stand-in; only the low 16 addresses are exercised.
    logic [31:0] mem [16];
    int          reset_writes = 0;
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr[3:0]] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr[3:0]];
        end
        if (!arst_n_in && sram_en && sram_we) reset_writes++;
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: logical memory (what a plain RAM would hold after every accepted
    // write), committed memory, and the pending-write queue.
    typedef struct {
        logic [19:0] a;
        logic [31:0] d;
    } wb_t;
    wb_t         q[$];
    logic [31:0] lmem [16];
    logic [31:0] cmem [16];
    int          hwait = 0;
    bit          m_stall = 0, m_gnt = 0;
    logic [31:0] exp_crd = '0, exp_hrd = '0;
    bit          exp_crv = 0, exp_hrv = 0;

    // Called at a settled point before the edge; returns #1 after the edge.
    task automatic step();
        bit          ch = 0, hh = 0, full, drain;
        int          slot;
        logic [31:0] crd, hrd;
        logic [19:0] exp_addr;
        foreach (q[i]) begin
            if (q[i].a == ctrl_raddr) ch = 1;
            if (q[i].a == host_addr)  hh = 1;
        end
        ch   = ch && ctrl_re;
        hh   = hh && host_req;
        full = (q.size() == 2);
        if (host_req && !hh && hwait == 4) slot = 1;
        else if (full)                     slot = 2;
        else if (ctrl_re && !ch)           slot = 3;
        else if (host_req && !hh)          slot = 4;
        else if (q.size() > 0)             slot = 5;
        else                               slot = 0;
        drain   = (slot == 2 || slot == 5);
        m_stall = (ctrl_re && !ch && slot != 3) || (ctrl_we && full && !drain);
        m_gnt   = host_req && (hh || slot == 1 || slot == 4);
        check("ctrl_stall", ctrl_stall, m_stall);
        check("host_gnt", host_gnt, m_gnt);
        check("sram_en", sram_en, slot != 0);
        if (slot != 0) begin
            exp_addr = drain ? q[0].a : (slot == 3 ? ctrl_raddr : host_addr);
            check("sram_we", sram_we, drain);
            check("sram_addr", sram_addr, exp_addr);
            if (drain) check("sram_wdata", sram_wdata, q[0].d);
        end
        crd = lmem[ctrl_raddr[3:0]];
        hrd = lmem[host_addr[3:0]];
        @(posedge clk);
        if (drain) begin
            cmem[q[0].a[3:0]] = q[0].d;
            void'(q.pop_front());
        end
        if (ctrl_we && !m_stall) begin
            q.push_back('{a: ctrl_waddr, d: ctrl_wdata});
            lmem[ctrl_waddr[3:0]] = ctrl_wdata;
        end
        if (m_gnt) hwait = 0;
        else if (host_req && hwait < 4) hwait++;
        exp_crv = ctrl_re && !m_stall;
        if (exp_crv) exp_crd = crd;
        exp_hrv = m_gnt;
        if (exp_hrv) exp_hrd = hrd;
        #1;
        check("ctrl_rvalid", ctrl_rvalid, exp_crv);
        check("ctrl_rdata", ctrl_rdata, exp_crd);
        check("host_rvalid", host_rvalid, exp_hrv);
        check("host_rdata", host_rdata, exp_hrd);
        check("wb_busy", wb_busy, q.size() > 0);
    endtask

    task automatic cycle();
        #1;
        step();
        @(negedge clk);
    endtask

    task automatic idle();
        ctrl_we = 0; ctrl_re = 0; host_req = 0;
    endtask

    typedef struct {
        logic        we;
        logic [19:0] wa;
        logic [31:0] wd;
        logic        re;
        logic [19:0] ra;
        logic        hr;
        logic [19:0] ha;
        logic        stall, gnt, en, swe;
        logic [19:0] sa;
        logic        crv;
        logic [31:0] crd;
        logic        hrv;
        logic [31:0] hrd;
    } vec_t;
    vec_t vt[11];

    initial begin
        int grant_cycle;
        int k;

        vt[0]  = '{0, 0, 0,       1, 5, 0, 0, 0, 0, 1, 0, 5, 1, 32'h11, 0, 0};
        vt[1]  = '{1, 3, 32'hA0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11, 0, 0};
        vt[2]  = '{0, 0, 0,       1, 3, 0, 0, 0, 0, 1, 1, 3, 1, 32'hA0, 0, 0};
        vt[3]  = '{1, 3, 32'hB0,  1, 3, 0, 0, 0, 0, 1, 0, 3, 1, 32'hA0, 0, 0};
        vt[4]  = '{1, 1, 32'hC1,  1, 2, 0, 0, 0, 0, 1, 0, 2, 1, 32'h0E, 0, 0};
        vt[5]  = '{1, 4, 32'hC4,  1, 6, 0, 0, 1, 0, 1, 1, 3, 0, 32'h0E, 0, 0};
        vt[6]  = '{1, 4, 32'hC4,  1, 6, 0, 0, 0, 0, 1, 0, 6, 1, 32'h12, 0, 0};
        vt[7]  = '{0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 32'h12, 0, 0};
        vt[8]  = '{1, 9, 32'h55,  0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 32'h12, 0, 0};
        vt[9]  = '{0, 0, 0,       1, 7, 1, 9, 0, 1, 1, 0, 7, 1, 32'h13, 1, 32'h55};
        vt[10] = '{0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 32'h13, 0, 32'h55};

        for (int i = 0; i < 16; i++) begin
            mem[i]  = 32'h0C + i;
            lmem[i] = 32'h0C + i;
            cmem[i] = 32'h0C + i;
        end
        arst_n_in = 0;
        idle();
        ctrl_waddr = '0; ctrl_raddr = '0; ctrl_wdata = '0; host_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_ctrl_rvalid", ctrl_rvalid, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        check("rst_ctrl_rdata", ctrl_rdata, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_wb_busy", wb_busy, 0);
        check("rst_sram_en", sram_en, 0);
        arst_n_in = 1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            ctrl_we = vt[i].we; ctrl_waddr = vt[i].wa; ctrl_wdata = vt[i].wd;
            ctrl_re = vt[i].re; ctrl_raddr = vt[i].ra;
            host_req = vt[i].hr; host_addr = vt[i].ha;
            #1;
            check("vec_stall", ctrl_stall, vt[i].stall);
            check("vec_gnt", host_gnt, vt[i].gnt);
            check("vec_sram_en", sram_en, vt[i].en);
            if (vt[i].en) begin
                check("vec_sram_we", sram_we, vt[i].swe);
                check("vec_sram_addr", sram_addr, vt[i].sa);
            end
            step();
            check("vec_crv", ctrl_rvalid, vt[i].crv);
            check("vec_crd", ctrl_rdata, vt[i].crd);
            check("vec_hrv", host_rvalid, vt[i].hrv);
            check("vec_hrd", host_rdata, vt[i].hrd);
            @(negedge clk);
        end

        // Host starvation under continuous controller traffic
        grant_cycle = -1;
        host_req = 1; host_addr = 7;
        for (k = 0; k < 20; k++) begin
            if (!m_stall || k == 0) begin
                ctrl_we = 1; ctrl_waddr = 20'(k % 6); ctrl_wdata = $urandom;
                ctrl_re = 1; ctrl_raddr = 20'(10 + k % 6);
            end
            #1;
            if (host_gnt) begin
                grant_cycle = k;
                check("starve_stall", ctrl_stall, 1);
            end
            step();
            @(negedge clk);
            if (grant_cycle >= 0) break;
        end
        check("starve_grant_cycle", grant_cycle, 4);
        idle();
        for (int n = 0; n < 10 && wb_busy; n++) cycle();
        check("drain_before_reset", wb_busy, 0);

        // Reset with two buffered writes and a read in flight
        ctrl_we = 1; ctrl_waddr = 2; ctrl_wdata = 32'hDEAD_0002; ctrl_re = 1; ctrl_raddr = 12;
        cycle();
        ctrl_we = 1; ctrl_waddr = 3; ctrl_wdata = 32'hDEAD_0003; ctrl_re = 1; ctrl_raddr = 13;
        #1;
        step();
        arst_n_in = 0;
        #1;
        check("mid_rst_ctrl_rvalid", ctrl_rvalid, 0);
        check("mid_rst_host_rvalid", host_rvalid, 0);
        check("mid_rst_ctrl_rdata", ctrl_rdata, 0);
        check("mid_rst_host_rdata", host_rdata, 0);
        check("mid_rst_wb_busy", wb_busy, 0);
        check("mid_rst_sram_en", sram_en, 0);
        repeat (3) @(negedge clk);
        check("rst_no_sram_writes", reset_writes, 0);
        idle();
        arst_n_in = 1;
        q.delete();
        hwait = 0; m_stall = 0; m_gnt = 0;
        exp_crd = '0; exp_hrd = '0;
        for (int i = 0; i < 16; i++) lmem[i] = cmem[i];
        @(negedge clk);

        // Random traffic obeying the hold-while-stalled / hold-until-granted rules
        for (int n = 0; n < 800; n++) begin
            if (!m_stall) begin
                ctrl_we = ($urandom % 2) == 0;
                ctrl_re = ($urandom % 2) == 0;
                ctrl_waddr = 20'($urandom % 8);
                ctrl_raddr = 20'($urandom % 8);
                ctrl_wdata = $urandom;
            end
            if (!(host_req && !m_gnt)) begin
                host_req = ($urandom % 4) == 0;
                host_addr = 20'($urandom % 8);
            end
            cycle();
        end
        idle();
        for (int n = 0; n < 10 && wb_busy; n++) cycle();
        check("final_wb_busy", wb_busy, 0);
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], lmem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
